// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg : bus widths, field offsets, load-op encoding and result packing
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_stage_pkg;

   localparam int ES_TO_MS_W = 78;
   localparam int MS_TO_WS_W = 70;
   localparam int MS_TO_DS_W = 38;

   // Field offsets inside the EX -> MEM bus
   localparam int ES_PC_LSB       = 0;
   localparam int ES_GR_WE_BIT    = 32;
   localparam int ES_RES_MEM_BIT  = 33;
   localparam int ES_DEST_LSB     = 34;
   localparam int ES_CALC_LSB     = 39;
   localparam int ES_ADDR_LO_LSB  = 71;
   localparam int ES_LD_OP_LSB    = 73;

   // One-hot load-op bit positions
   localparam int LD_W  = 0;
   localparam int LD_B  = 1;
   localparam int LD_BU = 2;
   localparam int LD_H  = 3;
   localparam int LD_HU = 4;

   typedef struct packed {
      logic [31:0] final_result;
      logic [4:0]  dest;
      logic        gr_we;
      logic [31:0] pc;
   } ms_to_ws_t;

   typedef struct packed {
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] final_result;
   } ms_to_ds_t;

   function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
      return {{24{sgn & b[7]}}, b};
   endfunction

   function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
      return {{16{sgn & h[15]}}, h};
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if : EX/WB/ID-facing handshake and bus signals of the MEM stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_stage_if;
   import mem_stage_pkg::*;

   logic                  ws_allow_in;
   logic                  ms_allow_in;
   logic                  es_to_ms_valid;
   logic [ES_TO_MS_W-1:0] es_to_ms_bus;
   logic [31:0]           data_sram_rdata;
   logic                  ms_to_ws_valid;
   logic [MS_TO_WS_W-1:0] ms_to_ws_bus;
   logic [MS_TO_DS_W-1:0] ms_to_ds_bus;

   // Pipeline neighbours (EX, SRAM, WB, ID) drive this side
   modport master (
      output ws_allow_in,
      input  ms_allow_in,
      output es_to_ms_valid,
      output es_to_ms_bus,
      output data_sram_rdata,
      input  ms_to_ws_valid,
      input  ms_to_ws_bus,
      input  ms_to_ds_bus
   );

   modport slave (
      input  ws_allow_in,
      output ms_allow_in,
      input  es_to_ms_valid,
      input  es_to_ms_bus,
      input  data_sram_rdata,
      output ms_to_ws_valid,
      output ms_to_ws_bus,
      output ms_to_ds_bus
   );

endinterface

`default_nettype wire

// File: rtl/mem_stage_load_align.sv
// ---------------------------------------------------------------------------
// load_align : selects byte/half/word from the SRAM word and sign/zero extends
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] raw_word,
   input  logic [1:0]  addr_lo,
   input  logic [4:0]  ld_op,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = raw_word[7:0];
      case (addr_lo)
         2'd0: byte_sel = raw_word[7:0];
         2'd1: byte_sel = raw_word[15:8];
         2'd2: byte_sel = raw_word[23:16];
         2'd3: byte_sel = raw_word[31:24];
      endcase
      half_sel = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

      // An empty op vector yields zero rather than any stale lane
      load_data = '0;
      if (ld_op[LD_W])
         load_data = raw_word;
      else if (ld_op[LD_B])
         load_data = ext_byte(byte_sel, 1'b1);
      else if (ld_op[LD_BU])
         load_data = ext_byte(byte_sel, 1'b0);
      else if (ld_op[LD_H])
         load_data = ext_half(half_sel, 1'b1);
      else if (ld_op[LD_HU])
         load_data = ext_half(half_sel, 1'b0);
   end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage : MEM pipeline stage, completes loads and forwards to WB / ID.
// Optional MS_ZERO_DEST_FILTER_EN suppresses gr_we for dest 0.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   mem_stage_if.slave  bus
);

   localparam logic MS_READY_GO = 1'b1;

   logic                  ms_valid;
   logic                  first;
   logic                  hold_vld;
   logic [31:0]           hold_data;
   logic [ES_TO_MS_W-1:0] es_bus_r;

   logic        ms_allow_in;
   logic        ms_to_ws_valid;
   logic        enter;
   logic        leave;

   logic [31:0] pc;
   logic        gr_we;
   logic        res_from_mem;
   logic [4:0]  dest;
   logic [31:0] calc_result;
   logic [1:0]  addr_lo;
   logic [4:0]  ld_op;

   logic        gr_we_out;
   logic [31:0] raw_word;
   logic [31:0] load_data;
   logic [31:0] final_result;
   ms_to_ws_t   ws_pkt;
   ms_to_ds_t   ds_pkt;

   assign pc           = es_bus_r[ES_PC_LSB +: 32];
   assign gr_we        = es_bus_r[ES_GR_WE_BIT];
   assign res_from_mem = es_bus_r[ES_RES_MEM_BIT];
   assign dest         = es_bus_r[ES_DEST_LSB +: 5];
   assign calc_result  = es_bus_r[ES_CALC_LSB +: 32];
   assign addr_lo      = es_bus_r[ES_ADDR_LO_LSB +: 2];
   assign ld_op        = es_bus_r[ES_LD_OP_LSB +: 5];

   assign ms_allow_in    = !ms_valid || (MS_READY_GO && bus.ws_allow_in);
   assign ms_to_ws_valid = ms_valid && MS_READY_GO;
   assign enter          = bus.es_to_ms_valid && ms_allow_in;
   assign leave          = ms_to_ws_valid && bus.ws_allow_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid  <= 1'b0;
         es_bus_r  <= '0;
         first     <= 1'b0;
         hold_vld  <= 1'b0;
         hold_data <= '0;
      end else begin
         if (ms_allow_in)
            ms_valid <= bus.es_to_ms_valid;
         if (enter)
            es_bus_r <= bus.es_to_ms_bus;
         first <= enter;

         // SRAM data is only valid in the first MEM cycle; capture it if WB stalls then
         if (leave || enter) begin
            hold_vld <= 1'b0;
         end else if (first && ms_valid && res_from_mem && !bus.ws_allow_in) begin
            hold_vld  <= 1'b1;
            hold_data <= bus.data_sram_rdata;
         end
      end
   end

   assign raw_word = hold_vld ? hold_data : bus.data_sram_rdata;

   load_align u_load_align (
      .raw_word  (raw_word),
      .addr_lo   (addr_lo),
      .ld_op     (ld_op),
      .load_data (load_data)
   );

   assign final_result = res_from_mem ? load_data : calc_result;

`ifdef MS_ZERO_DEST_FILTER_EN
   assign gr_we_out = gr_we && (dest != 5'd0);
`else
   assign gr_we_out = gr_we;
`endif

   assign ws_pkt.final_result = final_result;
   assign ws_pkt.dest         = dest;
   assign ws_pkt.gr_we        = gr_we_out;
   assign ws_pkt.pc           = pc;

   assign ds_pkt.gr_we        = gr_we_out && ms_valid;
   assign ds_pkt.dest         = dest;
   assign ds_pkt.final_result = final_result;

   assign bus.ms_allow_in    = ms_allow_in;
   assign bus.ms_to_ws_valid = ms_to_ws_valid;
   assign bus.ms_to_ws_bus   = ws_pkt;
   assign bus.ms_to_ds_bus   = ds_pkt;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage : directed scoreboard bench for mem_stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   typedef struct {
      logic [31:0] pc;
      logic        we;
      logic [4:0]  dest;
      logic [31:0] res;
   } exp_t;

   exp_t exp_q[$];

   mem_stage_if m();

   mem_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (m)
   );

   always #5 clk = ~clk;

   localparam logic [4:0] OP_W  = 5'b00001;
   localparam logic [4:0] OP_B  = 5'b00010;
   localparam logic [4:0] OP_BU = 5'b00100;
   localparam logic [4:0] OP_H  = 5'b01000;
   localparam logic [4:0] OP_HU = 5'b10000;

   logic [4:0]  ld_op_a [10] = '{OP_B, OP_H, OP_BU, OP_HU, OP_B, OP_H, OP_W, OP_BU, 5'b00000, OP_B};
   logic [1:0]  alo_a   [10] = '{2'd3, 2'd2, 2'd3, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
   logic [31:0] rd_a    [10] = '{32'h80FF7F01, 32'h80017FFF, 32'h80FF7F01, 32'h80017FFF, 32'h80FF7F01,
                                 32'h80017FFF, 32'hCAFEF00D, 32'h1234AB78, 32'h55555555, 32'h0000007F};
   logic [31:0] res_a   [10] = '{32'hFFFFFF80, 32'hFFFF8001, 32'h00000080, 32'h00008001, 32'hFFFFFFFF,
                                 32'h00007FFF, 32'hCAFEF00D, 32'h000000AB, 32'h00000000, 32'h0000007F};

   task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] want);
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, want);
      end
   endtask

   task automatic send(input logic [31:0] pc, input logic we, input logic rfm, input logic [4:0] dest,
                       input logic [31:0] calc, input logic [1:0] alo, input logic [4:0] op,
                       input logic [31:0] res);
      exp_t e;
      m.es_to_ms_valid = 1'b1;
      m.es_to_ms_bus   = {op, alo, calc, dest, rfm, we, pc};
      e.pc   = pc;
`ifdef MS_ZERO_DEST_FILTER_EN
      e.we   = we && (dest != 5'd0);
`else
      e.we   = we;
`endif
      e.dest = dest;
      e.res  = res;
      exp_q.push_back(e);
   endtask

   task automatic sb_check();
      exp_t e;
      if (m.ms_to_ws_valid === 1'b1 && m.ws_allow_in === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_out", {69'd0, m.ms_to_ws_valid}, 70'd0);
         end else begin
            e = exp_q.pop_front();
            chk("ws_bus", m.ms_to_ws_bus, {e.res, e.dest, e.we, e.pc});
            chk("ds_bus", {32'd0, m.ms_to_ds_bus}, {32'd0, e.we, e.dest, e.res});
         end
      end
   endtask

   // Present rdata for the current cycle, score any retiring instruction, advance one clock
   task automatic run_cycle(input logic [31:0] rd);
      logic acc;
      m.data_sram_rdata = rd;
      #1;
      sb_check();
      acc = m.es_to_ms_valid && m.ms_allow_in;
      @(posedge clk);
      #1;
      if (acc) begin
         m.es_to_ms_valid = 1'b0;
         m.es_to_ms_bus   = '0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t dropped;
      reset             = 1'b1;
      m.ws_allow_in     = 1'b1;
      m.es_to_ms_valid  = 1'b0;
      m.es_to_ms_bus    = '0;
      m.data_sram_rdata = '0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("rst_ws_valid", {69'd0, m.ms_to_ws_valid}, 70'd0);
      chk("rst_allow_in", {69'd0, m.ms_allow_in}, 70'd1);
      chk("rst_ws_bus", m.ms_to_ws_bus, 70'd0);
      chk("rst_ds_bus", {32'd0, m.ms_to_ds_bus}, 70'd0);
      reset = 1'b0;

      // ALU passthrough, then a dest-0 ALU op back to back
      send(32'h100, 1'b1, 1'b0, 5'd5, 32'h12345678, 2'd0, 5'd0, 32'h12345678);
      run_cycle(32'h0);
      chk("alu_valid", {69'd0, m.ms_to_ws_valid}, 70'd1);
      send(32'h104, 1'b1, 1'b0, 5'd0, 32'h0000ABCD, 2'd0, 5'd0, 32'h0000ABCD);
      run_cycle(32'h0);
      run_cycle(32'h0);

      // Back-to-back loads, each with its own SRAM word
      for (int i = 0; i < 10; i++) begin
         if (i > 0)
            chk("b2b_allow_in", {69'd0, m.ms_allow_in}, 70'd1);
         send(32'h200 + 32'(4 * i), 1'b1, 1'b1, 5'(i + 1), 32'hAAAA0000 | 32'(i),
              alo_a[i], ld_op_a[i], res_a[i]);
         run_cycle((i == 0) ? 32'h0 : rd_a[i-1]);
      end
      run_cycle(rd_a[9]);

      // WB stall of three cycles across a load; SRAM word disappears after cycle one
      send(32'h300, 1'b1, 1'b1, 5'd7, 32'h0, 2'd0, OP_W, 32'hDEADBEEF);
      run_cycle(32'h0);
      m.ws_allow_in = 1'b0;
      run_cycle(32'hDEADBEEF);
      for (int k = 0; k < 2; k++) begin
         m.data_sram_rdata = 32'h0;
         #1;
         chk("stall_allow_in", {69'd0, m.ms_allow_in}, 70'd0);
         chk("stall_valid", {69'd0, m.ms_to_ws_valid}, 70'd1);
         chk("stall_ds_result", {38'd0, m.ms_to_ds_bus[31:0]}, {38'd0, 32'hDEADBEEF});
         chk("stall_ws_result", {38'd0, m.ms_to_ws_bus[69:38]}, {38'd0, 32'hDEADBEEF});
         if (k == 1)
            send(32'h304, 1'b1, 1'b0, 5'd8, 32'h0F0F0F0F, 2'd0, 5'd0, 32'h0F0F0F0F);
         run_cycle(32'h0);
      end
      m.ws_allow_in = 1'b1;
      run_cycle(32'h0);
      run_cycle(32'h0);

      // Reset while a captured load is stalled
      send(32'h400, 1'b1, 1'b1, 5'd9, 32'h0, 2'd0, OP_W, 32'h11112222);
      run_cycle(32'h0);
      m.ws_allow_in = 1'b0;
      run_cycle(32'h11112222);
      run_cycle(32'h0);
      dropped = exp_q.pop_back();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_stall_ws_valid", {69'd0, m.ms_to_ws_valid}, 70'd0);
      chk("rst_stall_ds_we", {69'd0, m.ms_to_ds_bus[37]}, 70'd0);
      chk("rst_stall_allow_in", {69'd0, m.ms_allow_in}, 70'd1);
      m.ws_allow_in = 1'b1;
      send(32'h500, 1'b1, 1'b1, 5'd10, 32'h0, 2'd0, OP_W, 32'h0BADF00D);
      run_cycle(32'h0);
      run_cycle(32'h0BADF00D);

      chk("sb_drain", 70'(exp_q.size()), 70'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
